matrix_elementwise: RTL and testbench
=====================================

// Module: matrix_elementwise
// PURPOSE
//  Parametrised element-wise matrix unit; next generation of the fixed 4x4 adder.
//  Computes C = op(A, B) over a ROWSxCOLS tile, LANES elements per cycle, row-major.
//  Runtime op select: ADD/SUB/MAX/MIN. Signed or unsigned operands. start/done handshake.
//  Sits in the NPU datapath beside the matmul engine: bias add, residual add, ReLU-style clamp (MAX vs 0).
// PARAMETERS
//  ROWS    4   tile rows
//  COLS    4   tile columns
//  IN_W    8   operand width (a, b)
//  OUT_W   16  result width; elaboration error if OUT_W < IN_W
//  LANES   4   elements per cycle; elaboration error if ROWS*COLS % LANES != 0
//  SIGNED  0   1: operands two's complement, sign-extended; 0: zero-extended
// PORTS
//  clk    in   1                     system clock
//  rst_n  in   1                     asynchronous active-low reset
//  start  in   1                     request; sampled only in IDLE
//  op     in   2                     npu_pkg::ewise_op_e; captured with start
//  a      in   [ROWS][COLS] x IN_W   operand A; held stable by the source while busy
//  b      in   [ROWS][COLS] x IN_W   operand B; held stable by the source while busy
//  c      out  [ROWS][COLS] x OUT_W  result matrix, registered
//  busy   out  1                     high in RUN
//  done   out  1                     one-cycle pulse when c is complete
// BEHAVIOUR
//  Reset: state=IDLE; c all 0; busy=0; done=0; beat counter=0. Asynchronous, effective mid-operation; partial results are discarded.
//  FSM: IDLE -(start)-> RUN -(last beat)-> DONE -> IDLE (DONE lasts exactly 1 cycle).
//  BEATS = ROWS*COLS/LANES. Beat t writes flat indices k = t*LANES .. t*LANES+LANES-1; k = i*COLS+j.
//  The start edge captures op and clears the beat counter. RUN lasts BEATS cycles with one beat per edge.
//  done=1 in DONE, i.e. BEATS+1 edges after the start edge.
//  start while busy or during DONE: ignored, no queueing. start held high: a new run begins from the IDLE following DONE.
//  c: elements not yet written keep their previous values. All of c is final when done=1.
//  c holds its value until overwritten by the next run.
//  Arithmetic: extend operands to OUT_W+1 (sign- or zero-extended per SIGNED), then compute:
//    ADD a+b; SUB a-b; MAX max(a,b); MIN min(a,b); comparisons honour SIGNED.
//  op encoding: 2'b00 ADD, 2'b01 SUB, 2'b10 MAX, 2'b11 MIN.
//  Without saturation: c = low OUT_W bits (wrap-around).
//  Unsigned SUB with a<b wraps, e.g. 1-2 = 16'hFFFF.
// CONFIGURATION
//  MATRIX_EWISE_SAT_EN defined: ADD/SUB results clamp to the OUT_W range.
//    Signed: [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Unsigned: [0, 2^OUT_W-1]; unsigned 1-2 -> 0.
//    MAX/MIN are unaffected.
//  Undefined: wrap-around as above; no clamp logic is generated.
// STRUCTURE
//  npu_pkg holds typedef enum logic [1:0] ewise_op_e {EWISE_ADD, EWISE_SUB, EWISE_MAX, EWISE_MIN}.
//  npu_pkg also holds typedef enum ewise_state_e {EW_IDLE, EW_RUN, EW_DONE}.
//  Sub-module ewise_lane (#IN_W, OUT_W, SIGNED): combinational op + optional clamp.
//    Instantiated LANES times; the top level owns the FSM, beat counter and c registers.
// TESTING
//  1 4x4, LANES=4, a=1, b=2, ADD, start 1 cycle -> busy 4 cycles, done at edge 5, all c=16'h0003.
//  2 SUB unsigned, a=1, b=2 -> c=16'hFFFF; with MATRIX_EWISE_SAT_EN -> c=0.
//  3 SIGNED=1: a=8'hFE(-2), b=8'h03, MAX -> c=3; MIN -> c=16'hFFFE.
//    Same pattern with SIGNED=0: MAX -> 16'h00FE.
//  4 OUT_W=8, SIGNED=1, a=b=8'h7F, ADD -> wrap 8'hFE; with MATRIX_EWISE_SAT_EN -> 8'h7F.
//  5 Pulse start again mid-RUN -> ignored, done exactly once.
//    Then rst_n low on beat 2 of a new run -> c=0, busy=0, done=0; a fresh run completes correctly.
//  6 LANES=1 and LANES=16 with a[i][j]=i*4+j, b=1, ADD -> c[i][j]=i*4+j+1.
//    done latency 17 and 2 edges respectively.

Source files
------------

// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared types for the NPU element-wise datapath.
//   ewise_op_e    : runtime operation select (ADD/SUB/MAX/MIN), 2-bit encoding
//   ewise_state_e : control FSM states of matrix_elementwise
// -----------------------------------------------------------------------------
package npu_pkg;

    typedef enum logic [1:0] {
        EWISE_ADD = 2'b00,
        EWISE_SUB = 2'b01,
        EWISE_MAX = 2'b10,
        EWISE_MIN = 2'b11
    } ewise_op_e;

    typedef enum logic [1:0] {
        EW_IDLE = 2'b00,
        EW_RUN  = 2'b01,
        EW_DONE = 2'b10
    } ewise_state_e;

endpackage : npu_pkg

// File: rtl/ewise_lane.sv
// -----------------------------------------------------------------------------
// ewise_lane
// One combinational element-wise lane: y = op(a, b).
// Operands are extended to OUT_W+1 bits (sign- or zero-extended by SIGNED) so
// the ADD/SUB result is exact before it is narrowed to OUT_W bits.
// Optional feature macro: MATRIX_EWISE_SAT_EN -- ADD/SUB clamp to the OUT_W
// range instead of wrapping; MAX/MIN are never clamped.
// Ports:
//   i_op : operation select (npu_pkg::ewise_op_e)
//   i_a  : operand A, IN_W bits
//   i_b  : operand B, IN_W bits
//   o_y  : result, OUT_W bits
// -----------------------------------------------------------------------------
module ewise_lane
    import npu_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0
) (
    input  ewise_op_e         i_op,
    input  logic [IN_W-1:0]   i_a,
    input  logic [IN_W-1:0]   i_b,
    output logic [OUT_W-1:0]  o_y
);

    localparam int EW = OUT_W + 1;

    logic [EW-1:0] w_a_ext;
    logic [EW-1:0] w_b_ext;
    logic [EW-1:0] w_res;
    logic          w_a_gt_b;

    // Operand extension to the exact-result width.
    always_comb begin
        if (SIGNED != 0) begin
            w_a_ext = {{(EW-IN_W){i_a[IN_W-1]}}, i_a};
            w_b_ext = {{(EW-IN_W){i_b[IN_W-1]}}, i_b};
        end else begin
            w_a_ext = {{(EW-IN_W){1'b0}}, i_a};
            w_b_ext = {{(EW-IN_W){1'b0}}, i_b};
        end
    end

    // Magnitude comparison honouring operand signedness.
    always_comb begin
        if (SIGNED != 0) begin
            w_a_gt_b = ($signed(w_a_ext) > $signed(w_b_ext));
        end else begin
            w_a_gt_b = (w_a_ext > w_b_ext);
        end
    end

    // Exact arithmetic / selection in EW bits.
    always_comb begin
        w_res = w_a_ext;
        case (i_op)
            EWISE_ADD: w_res = w_a_ext + w_b_ext;
            EWISE_SUB: w_res = w_a_ext - w_b_ext;
            EWISE_MAX: w_res = w_a_gt_b ? w_a_ext : w_b_ext;
            EWISE_MIN: w_res = w_a_gt_b ? w_b_ext : w_a_ext;
            default:   w_res = w_a_ext;
        endcase
    end

`ifdef MATRIX_EWISE_SAT_EN
    logic [OUT_W-1:0] w_sat;

    // Clamp ADD/SUB results that do not fit in OUT_W bits.
    // Signed: the exact value fits in EW bits, so overflow shows as the top two
    // bits disagreeing; the top bit then gives the direction.
    // Unsigned: a set top bit means above max for ADD, below zero for SUB.
    always_comb begin
        w_sat = w_res[OUT_W-1:0];
        if ((i_op == EWISE_ADD) || (i_op == EWISE_SUB)) begin
            if (SIGNED != 0) begin
                if (w_res[EW-1] != w_res[EW-2]) begin
                    w_sat = w_res[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
                end else begin
                    w_sat = w_res[OUT_W-1:0];
                end
            end else begin
                if (w_res[EW-1]) begin
                    w_sat = (i_op == EWISE_SUB) ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
                end else begin
                    w_sat = w_res[OUT_W-1:0];
                end
            end
        end else begin
            w_sat = w_res[OUT_W-1:0];
        end
    end

    assign o_y = w_sat;
`else
    // Wrap-around build: the extra guard bit is only needed for clamping.
    logic w_unused_msb;
    assign w_unused_msb = w_res[EW-1];
    assign o_y          = w_res[OUT_W-1:0];
`endif

endmodule : ewise_lane

// File: rtl/matrix_elementwise.sv
// -----------------------------------------------------------------------------
// matrix_elementwise
// Element-wise matrix unit: C = op(A, B) over a ROWSxCOLS tile, LANES elements
// per cycle in row-major order (flat index k = i*COLS + j).
// Optional feature macro: MATRIX_EWISE_SAT_EN (saturating ADD/SUB in the lanes).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   start : run request, sampled only in IDLE
//   op    : operation (npu_pkg::ewise_op_e), captured with start
//   a, b  : operand tiles, held stable by the source while busy
//   c     : registered result tile
//   busy  : high while beats are being computed
//   done  : one-cycle pulse once all of c is final
// -----------------------------------------------------------------------------
module matrix_elementwise
    import npu_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int LANES  = 4,
    parameter int SIGNED = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  ewise_op_e                              op,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]    a,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]    b,
    output logic [ROWS-1:0][COLS-1:0][OUT_W-1:0]   c,
    output logic                                   busy,
    output logic                                   done
);

    localparam int N     = ROWS * COLS;
    localparam int BEATS = N / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (OUT_W < IN_W) begin : g_chk_out_w
        $error("matrix_elementwise: OUT_W must be >= IN_W");
    end
    if ((N % LANES) != 0) begin : g_chk_lanes
        $error("matrix_elementwise: ROWS*COLS must be a multiple of LANES");
    end

    ewise_state_e            r_state;
    ewise_state_e            w_next_state;
    ewise_op_e               r_op;
    logic [CNT_W-1:0]        r_beat;
    logic [N*OUT_W-1:0]      r_c;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_last_beat;
    logic [N*IN_W-1:0]       w_a_flat;
    logic [N*IN_W-1:0]       w_b_flat;
    logic [LANES*OUT_W-1:0]  w_lane_y;

    // Packed [ROWS][COLS] flattens so element k = i*COLS+j sits at k*IN_W.
    assign w_a_flat    = a;
    assign w_b_flat    = b;
    assign w_last_beat = (r_beat == CNT_W'(BEATS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IN_W-1:0] w_la;
        logic [IN_W-1:0] w_lb;

        assign w_la = w_a_flat[(int'(r_beat) * LANES + l) * IN_W +: IN_W];
        assign w_lb = w_b_flat[(int'(r_beat) * LANES + l) * IN_W +: IN_W];

        ewise_lane #(
            .IN_W   (IN_W),
            .OUT_W  (OUT_W),
            .SIGNED (SIGNED)
        ) u_lane (
            .i_op (r_op),
            .i_a  (w_la),
            .i_b  (w_lb),
            .o_y  (w_lane_y[l*OUT_W +: OUT_W])
        );
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the last beat,
    // DONE -> IDLE unconditionally (start is not looked at outside IDLE).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EW_IDLE: begin
                if (start) begin
                    w_next_state = EW_RUN;
                end else begin
                    w_next_state = EW_IDLE;
                end
            end
            EW_RUN: begin
                if (w_last_beat) begin
                    w_next_state = EW_DONE;
                end else begin
                    w_next_state = EW_RUN;
                end
            end
            EW_DONE: w_next_state = EW_IDLE;
            default: w_next_state = EW_IDLE;
        endcase
    end

    // State register and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EW_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == EW_RUN);
            r_done  <= (w_next_state == EW_DONE);
        end
    end

    // Op capture and beat counter: cleared by an accepted start, one step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= EWISE_ADD;
            r_beat <= {CNT_W{1'b0}};
        end else if ((r_state == EW_IDLE) && start) begin
            r_op   <= op;
            r_beat <= {CNT_W{1'b0}};
        end else if (r_state == EW_RUN) begin
            r_beat <= w_last_beat ? {CNT_W{1'b0}} : (r_beat + CNT_W'(1));
        end
    end

    // Result tile: each RUN cycle overwrites only the LANES elements of the
    // current beat; everything else keeps its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= {(N*OUT_W){1'b0}};
        end else if (r_state == EW_RUN) begin
            r_c[int'(r_beat) * (LANES*OUT_W) +: LANES*OUT_W] <= w_lane_y;
        end
    end

    assign c    = r_c;
    assign busy = r_busy;
    assign done = r_done;

endmodule : matrix_elementwise

// File: tb/tb_matrix_elementwise.sv
// -----------------------------------------------------------------------------
// tb_matrix_elementwise
// Three configurations of matrix_elementwise share operands and reset:
//   sel 0 : unsigned, OUT_W=16, LANES=4  (BEATS 4)
//   sel 1 : signed,   OUT_W=16, LANES=1  (BEATS 16)
//   sel 2 : signed,   OUT_W=8,  LANES=16 (BEATS 1)
// Expected results follow MATRIX_EWISE_SAT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_matrix_elementwise;
    import npu_pkg::*;

    logic clk;
    logic rst_n;
    ewise_op_e op;
    logic [3:0][3:0][7:0]  a;
    logic [3:0][3:0][7:0]  b;
    logic start_u, start_s, start_w;
    logic [3:0][3:0][15:0] c_u;
    logic [3:0][3:0][15:0] c_s;
    logic [3:0][3:0][7:0]  c_w;
    logic busy_u, busy_s, busy_w;
    logic done_u, done_s, done_w;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    matrix_elementwise #(.ROWS(4), .COLS(4), .IN_W(8), .OUT_W(16), .LANES(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start_u), .op(op), .a(a), .b(b),
        .c(c_u), .busy(busy_u), .done(done_u));

    matrix_elementwise #(.ROWS(4), .COLS(4), .IN_W(8), .OUT_W(16), .LANES(1), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .op(op), .a(a), .b(b),
        .c(c_s), .busy(busy_s), .done(done_s));

    matrix_elementwise #(.ROWS(4), .COLS(4), .IN_W(8), .OUT_W(8), .LANES(16), .SIGNED(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .op(op), .a(a), .b(b),
        .c(c_w), .busy(busy_w), .done(done_w));

    typedef struct {
        int          sel;
        ewise_op_e   vop;
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        ramp;   // a[k] = k, expected = exp + k
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [15:0] get_c(input int sel, input int k);
        if (sel == 0) return c_u[k/4][k%4];
        else if (sel == 1) return c_s[k/4][k%4];
        else return {8'h00, c_w[k/4][k%4]};
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_u : ((sel == 1) ? busy_s : busy_w);
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_u : ((sel == 1) ? done_s : done_w);
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_u = v;
        else if (sel == 1) start_s = v;
        else start_w = v;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_uniform(input logic [7:0] va, input logic [7:0] vb);
        for (int k = 0; k < 16; k++) begin
            a[k/4][k%4] = va;
            b[k/4][k%4] = vb;
        end
    endtask

    // One-cycle start pulse; returns edges until done and cycles with busy high.
    task automatic run(input int sel, input ewise_op_e o, output int lat, output int bcnt);
        @(negedge clk);
        op = o;
        set_start(sel, 1'b1);
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            set_start(sel, 1'b0);
            if (get_busy(sel)) bcnt++;
            if (get_done(sel)) break;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int cnt;
        logic [15:0] e;
        logic [15:0] sub_exp;

`ifdef MATRIX_EWISE_SAT_EN
        sub_exp = 16'h0000;
        vecs[7] = '{2, EWISE_ADD, 8'h7F, 8'h7F, 1'b0, 16'h007F, 2};
        vecs[8] = '{2, EWISE_SUB, 8'h80, 8'h01, 1'b0, 16'h0080, 2};
`else
        sub_exp = 16'hFFFF;
        vecs[7] = '{2, EWISE_ADD, 8'h7F, 8'h7F, 1'b0, 16'h00FE, 2};
        vecs[8] = '{2, EWISE_SUB, 8'h80, 8'h01, 1'b0, 16'h007F, 2};
`endif
        vecs[0]  = '{0, EWISE_ADD, 8'h01, 8'h02, 1'b0, 16'h0003, 5};
        vecs[1]  = '{0, EWISE_SUB, 8'h01, 8'h02, 1'b0, sub_exp,  5};
        vecs[2]  = '{0, EWISE_MAX, 8'hFE, 8'h03, 1'b0, 16'h00FE, 5};
        vecs[3]  = '{0, EWISE_MIN, 8'hFE, 8'h03, 1'b0, 16'h0003, 5};
        vecs[4]  = '{1, EWISE_MAX, 8'hFE, 8'h03, 1'b0, 16'h0003, 17};
        vecs[5]  = '{1, EWISE_MIN, 8'hFE, 8'h03, 1'b0, 16'hFFFE, 17};
        vecs[6]  = '{1, EWISE_ADD, 8'hFE, 8'h03, 1'b0, 16'h0001, 17};
        vecs[9]  = '{0, EWISE_ADD, 8'h00, 8'h01, 1'b1, 16'h0001, 5};
        vecs[10] = '{1, EWISE_ADD, 8'h00, 8'h01, 1'b1, 16'h0001, 17};
        vecs[11] = '{2, EWISE_ADD, 8'h00, 8'h01, 1'b1, 16'h0001, 2};
        vecs[12] = '{0, EWISE_ADD, 8'hFF, 8'hFF, 1'b0, 16'h01FE, 5};
        vecs[13] = '{1, EWISE_SUB, 8'h80, 8'h7F, 1'b0, 16'hFF01, 17};

        rst_n = 1'b0; start_u = 1'b0; start_s = 1'b0; start_w = 1'b0;
        op = EWISE_ADD;
        set_uniform(8'h00, 8'h00);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_c0_sel%0d", s), get_c(s, 0), 16'h0000);
            check($sformatf("reset_c15_sel%0d", s), get_c(s, 15), 16'h0000);
            check($sformatf("reset_busy_sel%0d", s), {15'h0, get_busy(s)}, 16'h0000);
            check($sformatf("reset_done_sel%0d", s), {15'h0, get_done(s)}, 16'h0000);
        end
        rst_n = 1'b1;

        // Table-driven vectors
        for (int v = 0; v < 14; v++) begin
            for (int k = 0; k < 16; k++) begin
                a[k/4][k%4] = vecs[v].ramp ? 8'(k) : vecs[v].va;
                b[k/4][k%4] = vecs[v].vb;
            end
            run(vecs[v].sel, vecs[v].vop, lat, bcnt);
            check($sformatf("v%0d_latency", v), 16'(lat), 16'(vecs[v].lat));
            check($sformatf("v%0d_busy_cycles", v), 16'(bcnt), 16'(vecs[v].lat - 1));
            for (int k = 0; k < 16; k++) begin
                e = vecs[v].ramp ? (vecs[v].exp + 16'(k)) : vecs[v].exp;
                if (vecs[v].sel == 2) e = {8'h00, e[7:0]};
                check($sformatf("v%0d_c%0d", v, k), get_c(vecs[v].sel, k), e);
            end
        end

        // Result holds after done
        set_uniform(8'h01, 8'h02);
        run(0, EWISE_ADD, lat, bcnt);
        repeat (3) @(negedge clk);
        check("hold_c15", get_c(0, 15), 16'h0003);

        // Partial update mid-run, then a start pulse inside RUN is ignored
        op = EWISE_SUB;
        start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        @(negedge clk);
        check("partial_c0_new", get_c(0, 0), sub_exp);
        check("partial_c4_old", get_c(0, 4), 16'h0003);
        check("partial_busy", {15'h0, busy_u}, 16'h0001);
        start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            if (done_u) cnt++;
            @(negedge clk);
        end
        check("midrun_start_done_count", 16'(cnt), 16'd1);
        check("midrun_c15", get_c(0, 15), sub_exp);

        // start held high: next run begins from the IDLE after DONE
        op = EWISE_ADD;
        start_u = 1'b1;
        lat = 0;
        while (!done_u && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("held_first_latency", 16'(lat), 16'd5);
        lat = 0;
        @(negedge clk);
        lat++;
        while (!done_u && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        start_u = 1'b0;
        check("held_second_gap", 16'(lat), 16'd6);
        check("held_c0", get_c(0, 0), 16'h0003);
        repeat (2) @(negedge clk);
        check("held_no_third_busy", {15'h0, busy_u}, 16'h0000);

        // Asynchronous reset during a run discards partial results
        set_uniform(8'h05, 8'h06);
        start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prereset_c0", get_c(0, 0), 16'h000B);
        rst_n = 1'b0;
        #1;
        check("midreset_c0", get_c(0, 0), 16'h0000);
        check("midreset_c15", get_c(0, 15), 16'h0000);
        check("midreset_busy", {15'h0, busy_u}, 16'h0000);
        check("midreset_done", {15'h0, done_u}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        set_uniform(8'h01, 8'h02);
        run(0, EWISE_ADD, lat, bcnt);
        check("postreset_latency", 16'(lat), 16'd5);
        check("postreset_c0", get_c(0, 0), 16'h0003);
        check("postreset_c15", get_c(0, 15), 16'h0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_matrix_elementwise
